chan_sel_pipe: RTL and testbench

// - Parametrised, registered N-channel selector for the slug simulator datapath; successor to the fixed 4:1 coordinate mux.
// - Picks one WIDTH-bit word from NCH channels by direct index or round-robin scan; result held in a valid/ready output stage.
// - Sits between object-coordinate producers (slug, obstacles, pickups) and the single renderer/collision consumer.

---
 rtl/chan_sel_pkg.sv | 17 +
 rtl/chan_sel_pipe_if.sv | 34 +++
 rtl/rr_pick.sv | 38 +++
 rtl/chan_sel_pipe.sv | 121 ++++++++++++
 tb/tb_chan_sel_pipe.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/chan_sel_pkg.sv
// Shared types and helpers for the N-channel coordinate selector.
// Holds the selection-mode encoding and the derived index-width rule.
package chan_sel_pkg;

    typedef enum logic {
        SEL_DIRECT = 1'b0,
        SEL_SCAN   = 1'b1
    } sel_mode_t;

    localparam int MAX_NCH = 16;

    // Index width for n channels; never below one bit.
    function automatic int sel_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/chan_sel_pipe_if.sv
// Bundle between the coordinate producers and the selector/consumer side.
// Valid/ready: a word moves on the output when out_valid and out_ready are both high at a rising edge.
interface chan_sel_pipe_if
    import chan_sel_pkg::*;
#(
    parameter int WIDTH = 11,
    parameter int NCH   = 4
);
    localparam int SELW = sel_w(NCH);

    logic                   mode;
    logic [SELW-1:0]        sel_in;
    logic [NCH*WIDTH-1:0]   in_bus;
    logic [NCH-1:0]         in_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       out_data;
    logic [SELW-1:0]        out_ch;
    logic                   out_valid;
    logic [NCH-1:0]         in_taken;
    logic                   sel_err;
    sel_mode_t              dbg_state;
    logic [SELW-1:0]        dbg_rr_ptr;

    modport master (
        output mode, sel_in, in_bus, in_valid, out_ready,
        input  out_data, out_ch, out_valid, in_taken, sel_err, dbg_state, dbg_rr_ptr
    );

    modport slave (
        input  mode, sel_in, in_bus, in_valid, out_ready,
        output out_data, out_ch, out_valid, in_taken, sel_err, dbg_state, dbg_rr_ptr
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational rotated-priority picker: first requester at or after ptr_i, wrapping mod NCH.
// Works for any NCH, not only powers of two.
module rr_pick
    import chan_sel_pkg::*;
#(
    parameter  int NCH  = 4,
    localparam int SELW = sel_w(NCH)
) (
    input  logic [NCH-1:0]  req_i,
    input  logic [SELW-1:0] ptr_i,
    output logic [NCH-1:0]  gnt_oh_o,
    output logic [SELW-1:0] gnt_idx_o,
    output logic            any_o
);

    int              j;
    logic [SELW-1:0] jj;

    always_comb begin
        gnt_oh_o  = '0;
        gnt_idx_o = '0;
        any_o     = 1'b0;
        j         = 0;
        jj        = '0;
        for (int i = 0; i < NCH; i++) begin
            // ptr_i is always below NCH, so one subtraction is enough to wrap.
            j = int'(ptr_i) + i;
            if (j >= NCH) j = j - NCH;
            jj = j[SELW-1:0];
            if (!any_o && req_i[jj]) begin
                any_o        = 1'b1;
                gnt_oh_o[jj] = 1'b1;
                gnt_idx_o    = jj;
            end
        end
    end

endmodule

// File: rtl/chan_sel_pipe.sv
// Registered N-channel selector: direct index or round-robin scan into a one-word valid/ready stage.
// Mode is registered, so a mode change takes effect on the cycle after it is presented.
module chan_sel_pipe
    import chan_sel_pkg::*;
#(
    parameter  int WIDTH = 11,
    parameter  int NCH   = 4,
    localparam int SELW  = sel_w(NCH)
) (
    input  logic           clk,
    input  logic           rst_n,
    chan_sel_pipe_if.slave bus
);

    localparam int              LAST_I  = NCH - 1;
    localparam logic [SELW:0]   NCH_W   = NCH[SELW:0];
    localparam logic [SELW-1:0] LAST_CH = LAST_I[SELW-1:0];

    if (NCH < 2 || NCH > MAX_NCH) begin : g_bad_nch
        $error("chan_sel_pipe: NCH out of range");
    end

    sel_mode_t        state_q, state_d;
    logic [SELW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SELW-1:0]  out_ch_q, out_ch_d;
    logic             out_valid_q, out_valid_d;
    logic             sel_err_q, sel_err_d;

    logic [NCH-1:0]   gnt_oh, dir_oh, cap_oh, in_taken;
    logic [SELW-1:0]  gnt_idx, cap_idx;
    logic [WIDTH-1:0] cap_data;
    logic             gnt_any, slot_free, sel_ok, capture;

    rr_pick #(.NCH(NCH)) u_pick (
        .req_i     (bus.in_valid),
        .ptr_i     (rr_ptr_q),
        .gnt_oh_o  (gnt_oh),
        .gnt_idx_o (gnt_idx),
        .any_o     (gnt_any)
    );

    // Direct-mode request decode; an out-of-range index matches no channel.
    always_comb begin
        dir_oh = '0;
        sel_ok = ({1'b0, bus.sel_in} < NCH_W);
        for (int k = 0; k < NCH; k++) begin
            dir_oh[k] = (bus.sel_in == SELW'(k)) && bus.in_valid[k];
        end
    end

    always_comb begin
        state_d     = sel_mode_t'(bus.mode);
        rr_ptr_d    = rr_ptr_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        sel_err_d   = sel_err_q;
        cap_data    = '0;
        slot_free   = !out_valid_q || bus.out_ready;

        if (state_q == SEL_SCAN) begin
            cap_oh  = gnt_oh;
            cap_idx = gnt_idx;
            capture = slot_free && gnt_any;
        end else begin
            cap_oh  = dir_oh;
            cap_idx = bus.sel_in;
            capture = slot_free && (|dir_oh);
        end

        for (int k = 0; k < NCH; k++) begin
            cap_data = cap_data | ({WIDTH{cap_oh[k]}} & bus.in_bus[k*WIDTH +: WIDTH]);
        end

        if (slot_free) begin
            out_valid_d = capture;
            if (capture) begin
                out_data_d = cap_data;
                out_ch_d   = cap_idx;
            end
        end

        if (state_q == SEL_DIRECT && slot_free && !sel_ok) sel_err_d = 1'b1;

        if (state_q == SEL_SCAN && capture) begin
            rr_ptr_d = (gnt_idx == LAST_CH) ? '0 : gnt_idx + SELW'(1);
        end
        // Entering scan always restarts the rotation at channel 0.
        if (state_q == SEL_DIRECT && state_d == SEL_SCAN) rr_ptr_d = '0;

        in_taken = capture ? cap_oh : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= SEL_DIRECT;
            rr_ptr_q    <= '0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            sel_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            sel_err_q   <= sel_err_d;
        end
    end

    assign bus.out_data   = out_data_q;
    assign bus.out_ch     = out_ch_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.sel_err    = sel_err_q;
    assign bus.in_taken   = in_taken;
    assign bus.dbg_state  = state_q;
    assign bus.dbg_rr_ptr = rr_ptr_q;

endmodule

// File: tb/tb_chan_sel_pipe.sv
// Bench for chan_sel_pipe: a 4-channel and a 5-channel instance driven side by side
// and compared every cycle against a transaction-level model of the selection rules.
module tb_chan_sel_pipe;
    import chan_sel_pkg::*;

    localparam int W = 11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    chan_sel_pipe_if #(.WIDTH(W), .NCH(4)) if4 ();
    chan_sel_pipe_if #(.WIDTH(W), .NCH(5)) if5 ();

    chan_sel_pipe #(.WIDTH(W), .NCH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
    chan_sel_pipe #(.WIDTH(W), .NCH(5)) dut5 (.clk(clk), .rst_n(rst_n), .bus(if5.slave));

    // stimulus, index 0 = 4-channel instance, 1 = 5-channel instance
    logic         mode_v[2];
    int           sel_v[2];
    logic [W-1:0] data_v[2][5];
    logic [4:0]   vld_v[2];
    logic         rdy_v[2];

    // reference model state
    logic         m_valid[2];
    logic [W-1:0] m_data[2];
    int           m_ch[2];
    logic         m_err[2];
    logic         m_state[2];
    int           m_ptr[2];
    logic [4:0]   m_taken[2];
    logic         p_take[2];
    int           p_k[2];
    logic         p_free[2];
    logic         p_err[2];

    // observed
    logic         o_valid[2];
    logic [W-1:0] o_data[2];
    int           o_ch[2];
    logic         o_err[2];
    logic         o_state[2];
    int           o_ptr[2];
    logic [4:0]   o_taken[2];
    logic [4:0]   pre_taken[2];

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int nch_of(input int d);
        return (d == 0) ? 4 : 5;
    endfunction

    task automatic apply();
        if4.mode      = mode_v[0];
        if4.sel_in    = 2'(sel_v[0]);
        if4.in_valid  = vld_v[0][3:0];
        if4.out_ready = rdy_v[0];
        for (int k = 0; k < 4; k++) if4.in_bus[k*W +: W] = data_v[0][k];
        if5.mode      = mode_v[1];
        if5.sel_in    = 3'(sel_v[1]);
        if5.in_valid  = vld_v[1];
        if5.out_ready = rdy_v[1];
        for (int k = 0; k < 5; k++) if5.in_bus[k*W +: W] = data_v[1][k];
    endtask

    task automatic sample();
        o_valid[0] = if4.out_valid;  o_valid[1] = if5.out_valid;
        o_data[0]  = if4.out_data;   o_data[1]  = if5.out_data;
        o_ch[0]    = int'(if4.out_ch);     o_ch[1]  = int'(if5.out_ch);
        o_err[0]   = if4.sel_err;    o_err[1]   = if5.sel_err;
        o_state[0] = if4.dbg_state;  o_state[1] = if5.dbg_state;
        o_ptr[0]   = int'(if4.dbg_rr_ptr); o_ptr[1] = int'(if5.dbg_rr_ptr);
        o_taken[0] = {1'b0, if4.in_taken};
        o_taken[1] = if5.in_taken;
    endtask

    // Decide what the current cycle's inputs should capture.
    task automatic predict(input int d);
        int nch;
        nch       = nch_of(d);
        p_free[d] = !m_valid[d] || rdy_v[d];
        p_take[d] = 1'b0;
        p_k[d]    = 0;
        p_err[d]  = m_err[d];
        if (!m_state[d]) begin
            if (sel_v[d] >= nch) begin
                if (p_free[d]) p_err[d] = 1'b1;
            end else if (p_free[d] && vld_v[d][sel_v[d]]) begin
                p_take[d] = 1'b1;
                p_k[d]    = sel_v[d];
            end
        end else if (p_free[d]) begin
            for (int off = 0; off < nch; off++) begin
                int k;
                k = (m_ptr[d] + off) % nch;
                if (!p_take[d] && vld_v[d][k]) begin
                    p_take[d] = 1'b1;
                    p_k[d]    = k;
                end
            end
        end
        m_taken[d] = p_take[d] ? (5'b1 << p_k[d]) : 5'b0;
    endtask

    task automatic commit(input int d);
        if (!rst_n) begin
            m_valid[d] = 1'b0; m_data[d] = '0; m_ch[d] = 0;
            m_err[d] = 1'b0; m_state[d] = 1'b0; m_ptr[d] = 0;
        end else begin
            if (p_free[d]) begin
                m_valid[d] = p_take[d];
                if (p_take[d]) begin
                    m_data[d] = data_v[d][p_k[d]];
                    m_ch[d]   = p_k[d];
                end
            end
            if (p_take[d] && m_state[d]) m_ptr[d] = (p_k[d] + 1) % nch_of(d);
            m_err[d] = p_err[d];
            if (!m_state[d] && mode_v[d]) m_ptr[d] = 0;
            m_state[d] = mode_v[d];
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        apply();
        #1;
        predict(0);
        predict(1);
        sample();
        for (int d = 0; d < 2; d++) begin
            pre_taken[d] = o_taken[d];
            if (rst_n) check($sformatf("d%0d_in_taken", d), o_taken[d], m_taken[d]);
        end
        @(posedge clk);
        commit(0);
        commit(1);
        #1;
        sample();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("d%0d_out_valid", d), o_valid[d], m_valid[d]);
            if (m_valid[d]) begin
                check($sformatf("d%0d_out_data", d), o_data[d], m_data[d]);
                check($sformatf("d%0d_out_ch", d), o_ch[d], m_ch[d]);
            end
            check($sformatf("d%0d_sel_err", d), o_err[d], m_err[d]);
            check($sformatf("d%0d_state", d), o_state[d], m_state[d]);
            check($sformatf("d%0d_rr_ptr", d), o_ptr[d], m_ptr[d]);
        end
    endtask

    task automatic rand_in(input int d, input bit allow_bad);
        int nch;
        nch = nch_of(d);
        if ($urandom_range(0, 7) == 0) mode_v[d] = ~mode_v[d];
        sel_v[d] = allow_bad ? int'($urandom_range(0, 7)) : int'($urandom_range(0, nch - 1));
        for (int k = 0; k < 5; k++) data_v[d][k] = 11'($urandom);
        vld_v[d] = 5'($urandom);
        rdy_v[d] = ($urandom_range(0, 3) != 0);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            mode_v[d] = 1'b0; sel_v[d] = 0; vld_v[d] = '0; rdy_v[d] = 1'b1;
            for (int k = 0; k < 5; k++) data_v[d][k] = '0;
            m_valid[d] = 1'b0; m_data[d] = '0; m_ch[d] = 0; m_err[d] = 1'b0;
            m_state[d] = 1'b0; m_ptr[d] = 0; m_taken[d] = '0;
            p_take[d] = 1'b0; p_k[d] = 0; p_free[d] = 1'b1; p_err[d] = 1'b0;
        end
        rst_n = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;

        repeat (20) begin
            rand_in(0, 1'b0); rand_in(1, 1'b0); cycle();
        end

        // reset in the middle of traffic
        rst_n = 1'b0;
        rand_in(0, 1'b0); rand_in(1, 1'b0);
        cycle();
        for (int d = 0; d < 2; d++) begin
            check("rst_out_valid", o_valid[d], 1'b0);
            check("rst_out_data", o_data[d], 11'h000);
            check("rst_out_ch", o_ch[d], 0);
            check("rst_sel_err", o_err[d], 1'b0);
        end
        rst_n = 1'b1;

        // direct mapping of every index on the 4-channel instance
        mode_v[0] = 1'b0; rdy_v[0] = 1'b1; vld_v[0] = 5'h0f;
        data_v[0][0] = 11'h010; data_v[0][1] = 11'h020;
        data_v[0][2] = 11'h030; data_v[0][3] = 11'h040;
        sel_v[0] = 2;
        rand_in(1, 1'b0); cycle();
        check("direct_sel2_data", o_data[0], 11'h030);
        check("direct_sel2_ch", o_ch[0], 2);
        for (int s = 0; s < 4; s++) begin
            sel_v[0] = s;
            rand_in(1, 1'b0); cycle();
            check("direct_map_data", o_data[0], (s + 1) * 16);
            check("direct_map_ch", o_ch[0], s);
        end

        // backpressure: held word survives changing inputs
        sel_v[0] = 1;
        rand_in(1, 1'b0); cycle();
        check("bp_capture", o_data[0], 11'h020);
        rdy_v[0] = 1'b0;
        repeat (3) begin
            for (int k = 0; k < 4; k++) data_v[0][k] = 11'($urandom);
            rand_in(1, 1'b0); cycle();
            check("bp_hold_data", o_data[0], 11'h020);
            check("bp_hold_valid", o_valid[0], 1'b1);
            check("bp_taken_zero", pre_taken[0], 5'b0);
        end
        rdy_v[0] = 1'b1; data_v[0][1] = 11'h055;
        rand_in(1, 1'b0); cycle();
        check("bp_release", o_data[0], 11'h055);

        // scan rotation and wrap
        mode_v[0] = 1'b1; vld_v[0] = 5'h0f;
        rand_in(1, 1'b0); cycle();
        for (int i = 0; i < 5; i++) begin
            rand_in(1, 1'b0); cycle();
            check("scan_all_ch", o_ch[0], i % 4);
        end
        vld_v[0] = 5'b01010;
        for (int i = 0; i < 4; i++) begin
            rand_in(1, 1'b0); cycle();
            check("scan_1010_ch", o_ch[0], (i % 2 == 0) ? 1 : 3);
        end
        vld_v[0] = 5'b0;
        repeat (2) begin
            rand_in(1, 1'b0); cycle();
            check("scan_idle_valid", o_valid[0], 1'b0);
            check("scan_idle_ptr", o_ptr[0], 0);
        end

        // switch back to direct, then into scan: first scan grant must be ch0
        vld_v[0] = 5'h0f; mode_v[0] = 1'b0; sel_v[0] = 3;
        rand_in(1, 1'b0); cycle();
        rand_in(1, 1'b0); cycle();
        check("switch_direct_ch", o_ch[0], 3);
        mode_v[0] = 1'b1;
        rand_in(1, 1'b0); cycle();
        check("switch_last_direct_ch", o_ch[0], 3);
        rand_in(1, 1'b0); cycle();
        check("switch_first_scan_ch", o_ch[0], 0);

        // out-of-range index on the 5-channel instance
        mode_v[1] = 1'b0; sel_v[1] = 0; vld_v[1] = 5'h1f; rdy_v[1] = 1'b1;
        rand_in(0, 1'b0); cycle();
        rand_in(0, 1'b0); cycle();
        sel_v[1] = 6;
        rand_in(0, 1'b0); cycle();
        check("bad_sel_valid", o_valid[1], 1'b0);
        check("bad_sel_err", o_err[1], 1'b1);
        sel_v[1] = 1;
        rand_in(0, 1'b0); cycle();
        check("bad_sel_err_sticky", o_err[1], 1'b1);
        check("bad_sel_recover_ch", o_ch[1], 1);

        // randomized traffic with occasional reset
        repeat (400) begin
            rst_n = ($urandom_range(0, 63) != 0);
            rand_in(0, 1'b0);
            rand_in(1, 1'b1);
            cycle();
        end
        rst_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
